brick_map_ctrl: RTL and testbench
=================================

# brick_map_ctrl

Owner of the 16×12 brick bitmap that feeds the VGA display's 192-bit `data` input. It arbitrates single-cycle write requests from the collision logic (clear one brick), the level loader (write one row) and the level start (fill all). It maintains a live brick count for end-of-level detection, and optionally runs a tick-paced fill sweep as a bring-up demo. It sits between game logic and the VGA display, and is the only writer of the bitmap.

## Interface
- `COLS`, default 16: bricks per row
- `ROWS`, default 12: brick rows
- `TICK_DIV`, default 1250000: sweep tick period in clocks; used only with `BRICK_SWEEP_EN`
- `clock` in 1: system / pixel clock (25 MHz); single clock domain
- `reset` in 1: asynchronous, active-low
- `clr_req` in 1: collision requester, clear brick at (`clr_row`, `clr_col`)
- `clr_col` in 4: column 0..15
- `clr_row` in 4: row 0..11
- `clr_ack` out 1: one-cycle grant pulse for `clr_req`
- `clr_hit` out 1: valid with `clr_ack`; 1 means the brick was present and has been removed
- `ld_req` in 1: level loader, write `ld_bits` into row `ld_row`
- `ld_row` in 4: row 0..11
- `ld_bits` in 16: bit c is column c
- `ld_ack` out 1: one-cycle grant pulse for `ld_req`
- `fill_req` in 1: set all 192 bricks
- `fill_ack` out 1: one-cycle grant pulse for `fill_req`
- `data` out 192: bitmap; index = row×16 + col
- `brick_cnt` out 8: number of set bits, 0..192
- `empty` out 1: registered, equal to (`brick_cnt` == 0)
- `busy` out 1: high while the recount is in progress; no grants are issued while high

## Operation
- FSM states:
  - IDLE: arbitrate.
  - RECOUNT: serial popcount, one row per cycle, rows 0..11.
- Fixed priority: clr > ld > fill > sweep. Exactly one grant per cycle, issued only in IDLE.
- Handshake:
  - The requester holds req and its operands stable until ack.
  - Ack is a single-cycle pulse.
  - The requester drops req the cycle after ack.
  - A req still high in the cycle after ack counts as a new request.
  - Dropping req before ack withdraws the request with no effect.
- Clear:
  - The brick bit is cleared.
  - `clr_hit` equals the old bit value.
  - `brick_cnt` is decremented only when `clr_hit`=1.
  - `clr_row` ≥ 12: ack with `clr_hit`=0, no change.
- Load:
  - The row is overwritten, `ld_ack` pulses, then the FSM enters RECOUNT.
  - `ld_row` ≥ 12: ack only, no change, no RECOUNT.
- Fill: all bits set, `brick_cnt` = 192, no RECOUNT.
- RECOUNT:
  - An accumulator sums the popcount of one row per cycle.
  - On row 11 it writes `brick_cnt` and `empty`, then returns to IDLE.
  - Requests arriving during RECOUNT wait; none are lost while held.
- Count arithmetic: 8-bit, never underflows (clear-hit implies cnt ≥ 1), never exceeds 192.
- Reset, asynchronous at any time including mid-RECOUNT:
  - `data` = 0, `brick_cnt` = 0, `empty` = 1.
  - All acks = 0, `clr_hit` = 0, `busy` = 0.
  - State = IDLE, sweep index = 0, tick counter = 0.

## Timing
- All outputs are registered.
- A req high at edge N in IDLE: ack, `clr_hit`, `data`, and (for clear/fill) `brick_cnt` and `empty` are visible after edge N.
- Load: `busy` is high from edge N+1 through edge N+12. Updated `brick_cnt` / `empty` are visible after edge N+12, and `busy` falls at the same edge. The next grant is possible at edge N+13.
- Clear or fill: the next grant is possible at edge N+1 (back-to-back).
- `data` changes at most once per cycle. The display samples it asynchronously to the frame; tearing is accepted.

## Configuration
- `BRICK_SWEEP_EN` defined:
  - A tick pulse is generated every `TICK_DIV`+1 clocks.
  - Each tick sets bit `sweep_idx` and increments both `brick_cnt` (if the bit was 0) and `sweep_idx`.
  - At `sweep_idx` = 192, the tick instead clears `data`, zeroes `brick_cnt` and resets `sweep_idx` to 0.
  - The sweep has lowest priority. A tick that coincides with busy or another grant is held pending, one deep; further ticks while pending are dropped.
- `BRICK_SWEEP_EN` undefined: no tick counter, no sweep index, no pending flag; `TICK_DIV` is ignored.

## Structure
- Package `brick_pkg`:
  - Constants `COLS`, `ROWS`, `CELLS` (192), `CNT_W` (8).
  - FSM state enum.
  - Function `cell_idx(row, col)`.
  - Function `row_popcnt(bits[15:0])`.
- Sub-module `brick_tick_gen`: divider producing the one-cycle tick; instantiated only under `BRICK_SWEEP_EN`.

## Test plan
- Reset mid-RECOUNT: pulse `reset` low during RECOUNT → `data` = 0, `brick_cnt` = 0, `empty` = 1, `busy` = 0 immediately.
- Fill then clears: `fill_req` → `brick_cnt` = 192. Clear (3,5) twice → first ack has `clr_hit` = 1, cnt = 191; second has `clr_hit` = 0, cnt = 191; `data[53]` = 0.
- Simultaneous requests: `clr_req` and `ld_req` rise together → `clr_ack` at N, `ld_ack` at N+1, `busy` for 12 cycles. Row 0 loaded with 0xF0F0 after fill → final cnt = 184.
- Out-of-range rows: `clr_row` = 12 and `ld_row` = 13 → acks issued, `data` and `brick_cnt` unchanged, no `busy`.
- Load to empty: load 0x0000 into all 12 rows from a full map → after the last recount `brick_cnt` = 0 and `empty` = 1.
- Sweep (`BRICK_SWEEP_EN`, `TICK_DIV` = 3): 192 ticks → `data` all ones, cnt = 192. Next tick → `data` = 0, cnt = 0. A tick colliding with `clr_req` is applied one cycle after `clr_ack`.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared constants, FSM state type and bitmap helpers for the brick map controller.
package brick_pkg;
    localparam int COLS  = 16;
    localparam int ROWS  = 12;
    localparam int CELLS = COLS * ROWS;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOUNT = 1'b1
    } state_t;

    // Row-major cell index: row*16 + col.
    function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

    function automatic logic [4:0] row_popcnt(input logic [15:0] bits);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, bits[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/brick_tick_gen.sv
// Free-running divider: one-cycle registered tick every TICK_DIV+1 clocks (sweep demo pacing).
module brick_tick_gen #(
    parameter int TICK_DIV = 1250000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap counter 0..TICK_DIV; tick is asserted on the wrap cycle.
    always_comb begin
        if (cnt_q == CNT_TOP) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/brick_map_ctrl.sv
// Sole writer of the 16x12 brick bitmap: arbitrates clear/load/fill requests and keeps a live brick count.
// Optional tick-paced fill sweep demo is built when BRICK_SWEEP_EN is defined.
module brick_map_ctrl #(
    parameter int COLS     = 16,
    parameter int ROWS     = 12,
    parameter int TICK_DIV = 1250000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr_req,
    input  logic [3:0]           clr_col,
    input  logic [3:0]           clr_row,
    output logic                 clr_ack,
    output logic                 clr_hit,
    input  logic                 ld_req,
    input  logic [3:0]           ld_row,
    input  logic [COLS-1:0]      ld_bits,
    output logic                 ld_ack,
    input  logic                 fill_req,
    output logic                 fill_ack,
    output logic [COLS*ROWS-1:0] data,
    output logic [7:0]           brick_cnt,
    output logic                 empty,
    output logic                 busy
);
    import brick_pkg::*;

    localparam logic [3:0]       ROW_LIM  = 4'(ROWS);
    localparam logic [3:0]       ROW_LAST = 4'(ROWS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(COLS * ROWS);

    state_t                 state_q, state_d;
    logic [COLS*ROWS-1:0]   data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [3:0]             row_q, row_d;
    logic                   empty_q, empty_d;
    logic                   busy_q, busy_d;
    logic                   clr_ack_q, clr_ack_d, clr_hit_q, clr_hit_d;
    logic                   ld_ack_q, ld_ack_d, fill_ack_q, fill_ack_d;
    logic [7:0]             clr_idx_s, ld_base_s, rc_base_s;
    logic [CNT_W-1:0]       rc_sum_s;

    assign clr_idx_s = cell_idx(clr_row, clr_col);
    assign ld_base_s = cell_idx(ld_row, 4'd0);
    assign rc_base_s = cell_idx(row_q, 4'd0);
    assign rc_sum_s  = acc_q + {3'b000, row_popcnt(data_q[rc_base_s +: COLS])};

`ifdef BRICK_SWEEP_EN
    logic       tick_s, sweep_go_s;
    logic       pend_q, pend_d;
    logic [7:0] sweep_idx_q, sweep_idx_d;

    brick_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick_s)
    );
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only an in-range load (not pre-empted by a clear) starts a recount.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!clr_req && ld_req && (ld_row < ROW_LIM)) begin
                    state_d = ST_RECOUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECOUNT: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOUNT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath: fixed-priority grant in IDLE, row-serial popcount in RECOUNT.
    always_comb begin
        data_d     = data_q;
        cnt_d      = cnt_q;
        empty_d    = empty_q;
        acc_d      = acc_q;
        row_d      = row_q;
        clr_ack_d  = 1'b0;
        clr_hit_d  = 1'b0;
        ld_ack_d   = 1'b0;
        fill_ack_d = 1'b0;
`ifdef BRICK_SWEEP_EN
        sweep_go_s  = 1'b0;
        sweep_idx_d = sweep_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    clr_ack_d = 1'b1;
                    if (clr_row < ROW_LIM) begin
                        clr_hit_d          = data_q[clr_idx_s];
                        data_d[clr_idx_s]  = 1'b0;
                        cnt_d              = cnt_q - {{(CNT_W-1){1'b0}}, data_q[clr_idx_s]};
                        empty_d            = (cnt_d == {CNT_W{1'b0}});
                    end else begin
                        clr_hit_d = 1'b0;
                    end
                end else if (ld_req) begin
                    ld_ack_d = 1'b1;
                    if (ld_row < ROW_LIM) begin
                        data_d[ld_base_s +: COLS] = ld_bits;
                        acc_d = {CNT_W{1'b0}};
                        row_d = 4'd0;
                    end else begin
                        row_d = row_q;
                    end
                end else if (fill_req) begin
                    fill_ack_d = 1'b1;
                    data_d     = {(COLS*ROWS){1'b1}};
                    cnt_d      = FULL_CNT;
                    empty_d    = 1'b0;
                end
`ifdef BRICK_SWEEP_EN
                else if (tick_s || pend_q) begin
                    sweep_go_s = 1'b1;
                    if (sweep_idx_q == FULL_CNT) begin
                        data_d      = {(COLS*ROWS){1'b0}};
                        cnt_d       = {CNT_W{1'b0}};
                        empty_d     = 1'b1;
                        sweep_idx_d = 8'd0;
                    end else begin
                        cnt_d               = cnt_q + {{(CNT_W-1){1'b0}}, ~data_q[sweep_idx_q]};
                        data_d[sweep_idx_q] = 1'b1;
                        empty_d             = 1'b0;
                        sweep_idx_d         = sweep_idx_q + 8'd1;
                    end
                end
`endif
                else begin
                    clr_ack_d = 1'b0;
                end
            end
            ST_RECOUNT: begin
                if (row_q == ROW_LAST) begin
                    cnt_d   = rc_sum_s;
                    empty_d = (rc_sum_s == {CNT_W{1'b0}});
                    acc_d   = {CNT_W{1'b0}};
                    row_d   = 4'd0;
                end else begin
                    acc_d = rc_sum_s;
                    row_d = row_q + 4'd1;
                end
            end
            default: begin
                acc_d = {CNT_W{1'b0}};
                row_d = 4'd0;
            end
        endcase
        busy_d = (state_d == ST_RECOUNT);
`ifdef BRICK_SWEEP_EN
        // One-deep pending: a tick arriving while one is already pending is dropped.
        pend_d = (pend_q || tick_s) && !sweep_go_s;
`endif
    end

    // Bitmap, count and handshake registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q     <= {(COLS*ROWS){1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
            acc_q      <= {CNT_W{1'b0}};
            row_q      <= 4'd0;
            clr_ack_q  <= 1'b0;
            clr_hit_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            fill_ack_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
            acc_q      <= acc_d;
            row_q      <= row_d;
            clr_ack_q  <= clr_ack_d;
            clr_hit_q  <= clr_hit_d;
            ld_ack_q   <= ld_ack_d;
            fill_ack_q <= fill_ack_d;
        end
    end

`ifdef BRICK_SWEEP_EN
    // Sweep position and pending-tick registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sweep_idx_q <= 8'd0;
            pend_q      <= 1'b0;
        end else begin
            sweep_idx_q <= sweep_idx_d;
            pend_q      <= pend_d;
        end
    end
`endif

    assign data      = data_q;
    assign brick_cnt = cnt_q;
    assign empty     = empty_q;
    assign busy      = busy_q;
    assign clr_ack   = clr_ack_q;
    assign clr_hit   = clr_hit_q;
    assign ld_ack    = ld_ack_q;
    assign fill_ack  = fill_ack_q;
endmodule

// File: tb/tb_brick_map_ctrl.sv
// Scoreboard bench for brick_map_ctrl: stimulus pushes expected acks/recount results, a monitor pops and compares.
module tb_brick_map_ctrl;
    logic         clock = 1'b0;
    logic         reset;
    logic         clr_req, ld_req, fill_req;
    logic [3:0]   clr_col, clr_row, ld_row;
    logic [15:0]  ld_bits;
    logic         clr_ack, clr_hit, ld_ack, fill_ack, empty, busy;
    logic [191:0] data;
    logic [7:0]   brick_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         kind;   // 0 clear, 1 load, 2 fill
        logic       hit;
        logic [7:0] cnt;
    } exp_t;

    exp_t       ack_q[$];
    logic [7:0] rc_q[$];
    logic       prev_busy = 1'b0;

    always #5 clock = ~clock;

    brick_map_ctrl #(.COLS(16), .ROWS(12), .TICK_DIV(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_col   (clr_col),
        .clr_row   (clr_row),
        .clr_ack   (clr_ack),
        .clr_hit   (clr_hit),
        .ld_req    (ld_req),
        .ld_row    (ld_row),
        .ld_bits   (ld_bits),
        .ld_ack    (ld_ack),
        .fill_req  (fill_req),
        .fill_ack  (fill_ack),
        .data      (data),
        .brick_cnt (brick_cnt),
        .empty     (empty),
        .busy      (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every grant and every recount completion against the scoreboard.
    always @(negedge clock) begin : mon
        exp_t       e;
        int         kind;
        logic [7:0] rc;
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (clr_ack || ld_ack || fill_ack) begin
                kind = clr_ack ? 0 : (ld_ack ? 1 : 2);
                check("ack_onehot", longint'(clr_ack) + longint'(ld_ack) + longint'(fill_ack), 1);
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", longint'(kind), -1);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_kind", longint'(kind), longint'(e.kind));
                    check("cnt_at_ack", longint'(brick_cnt), longint'(e.cnt));
                    check("empty_at_ack", longint'(empty), longint'(e.cnt == 8'd0));
                    if (kind == 0) check("clr_hit", longint'(clr_hit), longint'(e.hit));
                end
            end
            if (prev_busy && !busy) begin
                if (rc_q.size() == 0) begin
                    check("recount_unexpected", longint'(brick_cnt), -1);
                end else begin
                    rc = rc_q.pop_front();
                    check("recount_cnt", longint'(brick_cnt), longint'(rc));
                    check("recount_empty", longint'(empty), longint'(rc == 8'd0));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_ack(input int kind, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
            seen = (kind == 0) ? clr_ack : ((kind == 1) ? ld_ack : fill_ack);
        end
        check("ack_seen", longint'(seen), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("busy_released", longint'(busy), 0);
    endtask

    task automatic do_clr(input logic [3:0] r, input logic [3:0] c, input logic hit, input logic [7:0] cnt);
        int cyc;
        ack_q.push_back('{0, hit, cnt});
        clr_row = r; clr_col = c; clr_req = 1'b1;
        wait_ack(0, cyc);
        clr_req = 1'b0;
    endtask

    task automatic do_fill();
        int cyc;
        ack_q.push_back('{2, 1'b0, 8'd192});
        fill_req = 1'b1;
        wait_ack(2, cyc);
        fill_req = 1'b0;
    endtask

`ifndef BRICK_SWEEP_EN
    task automatic do_ld(input logic [3:0] r, input logic [15:0] bits,
                         input logic [7:0] ack_cnt, input logic [7:0] rc_cnt);
        int cyc;
        ack_q.push_back('{1, 1'b0, ack_cnt});
        rc_q.push_back(rc_cnt);
        ld_row = r; ld_bits = bits; ld_req = 1'b1;
        wait_ack(1, cyc);
        ld_req = 1'b0;
        wait_idle();
    endtask

    task automatic directed_test();
        int           cyc;
        int           n;
        logic [191:0] snap;
        // fill, then clear (3,5) twice
        do_fill();
        do_clr(4'd3, 4'd5, 1'b1, 8'd191);
        do_clr(4'd3, 4'd5, 1'b0, 8'd191);
        check("bit53_cleared", longint'(data[53]), 0);

        // clear and load raised together: clear wins, load follows next cycle
        do_fill();
        ack_q.push_back('{0, 1'b1, 8'd191});
        ack_q.push_back('{1, 1'b0, 8'd191});
        rc_q.push_back(8'd184);
        clr_row = 4'd0; clr_col = 4'd0; ld_row = 4'd0; ld_bits = 16'hF0F0;
        clr_req = 1'b1; ld_req = 1'b1;
        wait_ack(0, cyc);
        clr_req = 1'b0;
        check("clr_latency", longint'(cyc), 1);
        wait_ack(1, cyc);
        ld_req = 1'b0;
        check("ld_after_clr", longint'(cyc), 1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clock); #1;
        end
        check("busy_cycles", longint'(n), 12);
        check("row0_bits", longint'(data[15:0]), 64'hF0F0);
        check("cnt_184", longint'(brick_cnt), 184);

        // out-of-range rows
        snap = data;
        do_clr(4'd12, 4'd0, 1'b0, 8'd184);
        ack_q.push_back('{1, 1'b0, 8'd184});
        ld_row = 4'd13; ld_bits = 16'hFFFF; ld_req = 1'b1;
        wait_ack(1, cyc);
        ld_req = 1'b0;
        check("oor_no_busy", longint'(busy), 0);
        @(posedge clock); #1;
        check("oor_still_idle", longint'(busy), 0);
        check_data("oor_data", data, snap);
        check("oor_cnt", longint'(brick_cnt), 184);

        // zero every row from a full map
        do_fill();
        for (int r = 0; r < 12; r++) begin
            do_ld(4'(r), 16'h0000, 8'(192 - 16 * r), 8'(176 - 16 * r));
        end
        check("final_empty", longint'(empty), 1);
        check("final_cnt", longint'(brick_cnt), 0);
        check_data("final_data", data, 192'd0);

        // asynchronous reset in the middle of a recount
        do_fill();
        ack_q.push_back('{1, 1'b0, 8'd192});
        ld_row = 4'd0; ld_bits = 16'hFFFF; ld_req = 1'b1;
        wait_ack(1, cyc);
        ld_req = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        check("mid_recount_busy", longint'(busy), 1);
        reset = 1'b0;
        #1;
        check_data("rst_data", data, 192'd0);
        check("rst_cnt", longint'(brick_cnt), 0);
        check("rst_empty", longint'(empty), 1);
        check("rst_busy", longint'(busy), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("post_rst_busy", longint'(busy), 0);
    endtask
`else
    task automatic sweep_test();
        int cyc;
        int n;
        n = 0;
        while (brick_cnt != 8'd192 && n < 1200) begin @(posedge clock); #1; n++; end
        check("sweep_full_cnt", longint'(brick_cnt), 192);
        check_data("sweep_full_data", data, {192{1'b1}});
        n = 0;
        while (brick_cnt != 8'd0 && n < 20) begin @(posedge clock); #1; n++; end
        check("sweep_wrap_cnt", longint'(brick_cnt), 0);
        check_data("sweep_wrap_data", data, 192'd0);
        n = 0;
        while (brick_cnt != 8'd1 && n < 20) begin @(posedge clock); #1; n++; end
        check("sweep_first_bit", longint'(data[0]), 1);
        // next tick lands three edges later, together with a clear of (0,0)
        repeat (3) begin @(posedge clock); #1; end
        ack_q.push_back('{0, 1'b1, 8'd0});
        clr_row = 4'd0; clr_col = 4'd0; clr_req = 1'b1;
        wait_ack(0, cyc);
        clr_req = 1'b0;
        check("sweep_clr_latency", longint'(cyc), 1);
        check("sweep_held_bit1", longint'(data[1]), 0);
        @(posedge clock); #1;
        check("sweep_applied_bit1", longint'(data[1]), 1);
        check("sweep_cnt_after", longint'(brick_cnt), 1);
    endtask
`endif

    initial begin
        reset    = 1'b0;
        clr_req  = 1'b0; ld_req = 1'b0; fill_req = 1'b0;
        clr_col  = 4'd0; clr_row = 4'd0; ld_row = 4'd0; ld_bits = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check_data("reset_data", data, 192'd0);
        check("reset_cnt", longint'(brick_cnt), 0);
        check("reset_empty", longint'(empty), 1);
        check("reset_busy", longint'(busy), 0);
        check("reset_acks", longint'({clr_ack, clr_hit, ld_ack, fill_ack}), 0);
        reset = 1'b1;
        @(posedge clock); #1;
`ifdef BRICK_SWEEP_EN
        sweep_test();
`else
        directed_test();
`endif
        repeat (3) begin @(posedge clock); #1; end
        check("ack_queue_drained", longint'(ack_q.size()), 0);
        check("recount_queue_drained", longint'(rc_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
